seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 138 +++++++++++++
 tb/tb_seq_divider.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider (quotient -> LO, remainder -> HI).
// Define DIVU_SUPPORT_EN to add the div_unsigned input, which selects unsigned division.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef DIVU_SUPPORT_EN
    input  logic             div_unsigned,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [2:0] {IDLE, SETUP, ITER, FIX, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d, den_q, den_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [WIDTH:0]   part_q, part_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic             ge;
    logic             uns_q;
`ifdef DIVU_SUPPORT_EN
    logic             uns_d;
`else
    assign uns_q = 1'b0;
`endif

    // Next-state logic: num_q doubles as the dividend magnitude and the shifting quotient.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`ifdef DIVU_SUPPORT_EN
        uns_d   = uns_q;
`endif
        shifted = {part_q[WIDTH-1:0], num_q[WIDTH-1]};
        ge      = shifted >= {1'b0, den_q};
        case (state_q)
            IDLE: if (start) begin
                state_d = SETUP;
                num_d   = dividend;
                den_d   = divisor;
`ifdef DIVU_SUPPORT_EN
                uns_d   = div_unsigned;
`endif
            end
            SETUP: if (den_q == '0) begin
                state_d = DONE;
            end else begin
                state_d = ITER;
                num_d   = (!uns_q && num_q[WIDTH-1]) ? -num_q : num_q;
                den_d   = (!uns_q && den_q[WIDTH-1]) ? -den_q : den_q;
                qneg_d  = !uns_q && (num_q[WIDTH-1] ^ den_q[WIDTH-1]);
                rneg_d  = !uns_q && num_q[WIDTH-1];
                part_d  = '0;
                cnt_d   = '0;
            end
            ITER: begin
                part_d = ge ? shifted - {1'b0, den_q} : shifted;
                num_d  = {num_q[WIDTH-2:0], ge};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                quo_d   = qneg_q ? -num_q : num_q;
                rem_d   = rneg_q ? -part_q[WIDTH-1:0] : part_q[WIDTH-1:0];
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        dz_d   = state_q == SETUP && den_q == '0;
    end

    // State and registered outputs; reset abandons any in-flight division.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            num_q   <= '0;
            den_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

`ifdef DIVU_SUPPORT_EN
    // Signedness mode captured with the operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) uns_q <= 1'b0;
        else        uns_q <= uns_d;
    end
`endif

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider with directed vectors.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         div_unsigned = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef DIVU_SUPPORT_EN
        .div_unsigned(div_unsigned),
`endif
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .busy(busy),
        .done(done),
        .div_zero(div_zero)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result and its cycle.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_zero", div_zero, e.dz);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Present one request; when pushing, done is due WIDTH+3 edges (or 2 for /0) counting the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic u,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input bit push);
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor = b;
        div_unsigned = u;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        div_unsigned = 1'b0;
        if (push) begin
            e.q = eq;
            e.r = er;
            e.dz = edz;
            e.cyc = cyc + (edz ? 1 : W + 2);
            sb.push_back(e);
        end
        chk("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_within_bound", busy, 1'b0);
    endtask

    initial begin
        #2;
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_zero", div_zero, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        issue(100, 7, 0, 14, 2, 0, 1);
        wait_idle();
        issue(-32'sd100, 7, 0, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 1);
        wait_idle();
        issue(100, -32'sd7, 0, 32'hFFFFFFF2, 2, 0, 1);
        wait_idle();
        issue(100, 7, 0, 14, 2, 0, 1);
        wait_idle();
        issue(5, 0, 0, 14, 2, 1, 1);
        wait_idle();
        issue(32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 0, 1);
        wait_idle();

        // Reset in the middle of ITER: outputs clear at once, no done pulse follows.
        issue(1000, 7, 0, 0, 0, 0, 0);
        repeat (11) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(9, 3, 0, 3, 0, 0, 1);
        wait_idle();

        // Start re-pulsed during ITER is ignored.
        issue(77, 5, 0, 15, 2, 0, 1);
        repeat (6) @(negedge clk);
        dividend = 50;
        divisor = 3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Start presented while in DONE is ignored.
        issue(20, 6, 0, 3, 2, 0, 1);
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            #1;
        end
        chk("done_seen", done, 1);
        @(negedge clk);
        dividend = 99;
        divisor = 9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_in_done_ignored", busy, 0);

        issue(-32'sd7, -32'sd2, 0, 3, 32'hFFFFFFFF, 0, 1);
        wait_idle();
`ifdef DIVU_SUPPORT_EN
        issue(32'hFFFFFFFF, 2, 1, 32'h7FFFFFFF, 1, 0, 1);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
